// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response path: default widths used by both
// the capture-side chunk packer and the transmit-side word serializer, the
// chunk-count helpers, and the serializer state encoding.
package puf_pkg;

  localparam int RESP_W = 128;  // PUF response word width
  localparam int BYTE_W = 8;    // transmit path chunk width

  // Number of SZ_OUT chunks needed to cover SZ_IN bits.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Width of the word after MSB-side zero padding to a whole number of chunks.
  function automatic int pad_w(input int a, input int b);
    return ceil_div(a, b) * b;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// Unpacks one wide word into SZ_OUT-bit chunks, MSB chunk first, over a
// valid/ready stream. The word is zero-extended at the top to a whole number
// of chunks, so any padding lands in the first chunk.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - serialize data_in (taken only while not busy)
//   data_in     - word to send, sampled on the accepted start cycle
//   busy        - word in flight
//   data_out    - current chunk, stable while valid && !out_ready
//   valid       - data_out holds a chunk
//   out_ready   - downstream accepts; transfer on valid && out_ready
//   done        - one-cycle pulse after the final chunk transfer
module word_serializer
  import puf_pkg::*;
#(
  parameter int SZ_IN  = RESP_W,
  parameter int SZ_OUT = BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SZ_IN-1:0]  data_in,
  output logic              busy,
  output logic [SZ_OUT-1:0] data_out,
  output logic              valid,
  input  logic              out_ready,
  output logic              done
);

  localparam int COUNT = ceil_div(SZ_IN, SZ_OUT);
  localparam int PADW  = pad_w(SZ_IN, SZ_OUT);
  // One spare bit so the counter can reach COUNT without wrapping.
  localparam int CW    = $clog2(COUNT) + 1;

  state_t            state, state_nxt;
  logic [PADW-1:0]   shreg;
  logic [CW-1:0]     cnt;
  logic              done_q;
  logic              xfer, last;

  assign xfer = (state == SEND) && out_ready;
  assign last = (cnt == CW'(COUNT - 1));

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? SEND : IDLE;
      SEND:    state_nxt = (xfer && last) ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= PADW'(data_in);
            cnt   <= '0;
          end
        end
        SEND: begin
          if (xfer) begin
            // Zero fill: after the last shift the register is clear again,
            // so data_out reads 0 while idle.
            shreg <= shreg << SZ_OUT;
            cnt   <= cnt + CW'(1);
            if (last) done_q <= 1'b1;
          end
        end
        default: begin
          shreg  <= '0;
          cnt    <= '0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = (state == SEND);
  assign valid    = (state == SEND);
  assign data_out = shreg[PADW-1 -: SZ_OUT];
  assign done     = done_q;

endmodule

// File: tb/tb_word_serializer.sv
module tb_word_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- instance A: 128 -> 8 ----------------
  logic         start_a = 1'b0;
  logic [127:0] din_a = '0;
  logic         busy_a, valid_a, done_a;
  logic [7:0]   dout_a;
  logic         rdy_a = 1'b1;

  word_serializer #(.SZ_IN(128), .SZ_OUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(din_a),
    .busy(busy_a), .data_out(dout_a), .valid(valid_a),
    .out_ready(rdy_a), .done(done_a)
  );

  // ---------------- instance B: 12 -> 8 (padding) ----------------
  logic        start_b = 1'b0;
  logic [11:0] din_b = '0;
  logic        busy_b, valid_b, done_b;
  logic [7:0]  dout_b;
  logic        rdy_b = 1'b1;

  word_serializer #(.SZ_IN(12), .SZ_OUT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(din_b),
    .busy(busy_b), .data_out(dout_b), .valid(valid_b),
    .out_ready(rdy_b), .done(done_b)
  );

  // ---------------- instance C: 8 -> 8 (degenerate) ----------------
  logic       start_c = 1'b0;
  logic [7:0] din_c = '0;
  logic       busy_c, valid_c, done_c;
  logic [7:0] dout_c;
  logic       rdy_c = 1'b1;

  word_serializer #(.SZ_IN(8), .SZ_OUT(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .data_in(din_c),
    .busy(busy_c), .data_out(dout_c), .valid(valid_c),
    .out_ready(rdy_c), .done(done_c)
  );

  // ---------------- reference model + scoreboard for A ----------------
  logic [7:0] exp_q[$];
  int ntx = 0;        // transfers observed on A
  int dones = 0;      // done pulses observed on A
  int exp_dones = 0;

  // A 128-bit word is sixteen bytes, most significant byte leaves first.
  function automatic void model_push(input logic [127:0] w);
    for (int k = 0; k < 16; k++)
      exp_q.push_back(8'((w >> (8 * (15 - k))) & 128'hFF));
  endfunction

  logic       hold_pend = 1'b0;
  logic [7:0] held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) check("hold", {valid_a, dout_a}, {1'b1, held});
      if (valid_a) begin
        if (rdy_a) begin
          if (exp_q.size() == 0) begin
            check("unexpected_chunk", {valid_a, dout_a}, 9'h0);
          end else begin
            check("chunk", dout_a, exp_q.pop_front());
          end
          ntx++;
          hold_pend <= 1'b0;
        end else begin
          hold_pend <= 1'b1;
          held <= dout_a;
        end
      end
      if (done_a) dones++;
    end
  end

  // out_ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  int rmode = 0;
  int ph = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      1:       begin rdy_a = (ph == 0); ph = (ph + 1) % 3; end
      2:       rdy_a = ($urandom_range(0, 2) != 0);
      default: rdy_a = 1'b1;
    endcase
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (busy_a && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) check("idle_timeout", 1, 0);
  endtask

  // Drives start for one cycle from the current moment.
  task automatic start_word(input logic [127:0] w);
    model_push(w);
    start_a = 1'b1;
    din_a = w;
    @(posedge clk); #1;
    start_a = 1'b0;
    din_a = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Waits for done; returns at the negedge of the done cycle.
  task automatic finish_word(input bit timing, input bit poke);
    int n = 0;
    bit seen = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) check("first_latency", valid_a, 1'b1);
      if (poke && n == 4) begin start_a = 1'b1; din_a = '1; end
      if (poke && n == 6) start_a = 1'b0;
      if (done_a) begin seen = 1; break; end
    end
    check("done_seen", seen, 1'b1);
    if (timing) check("done_cycle", n, 17);
    check("busy_at_done", {busy_a, valid_a}, 2'b00);
    exp_dones++;
    check("done_count", dones + 1, exp_dones);  // monitor counts this edge too
  endtask

  task automatic run_b(input logic [11:0] w);
    logic [15:0] pad;
    int got = 0;
    int n = 0;
    pad = {4'h0, w};
    @(posedge clk); #1;
    start_b = 1'b1; din_b = w;
    @(posedge clk); #1;
    start_b = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (valid_b) begin
        check("b_chunk", dout_b, 8'((pad >> (8 * (1 - got))) & 16'hFF));
        got++;
      end
      if (done_b) break;
    end
    check("b_count", got, 2);
    check("b_done_cycle", n, 3);
  endtask

  task automatic run_c(input logic [7:0] w);
    @(posedge clk); #1;
    start_c = 1'b1; din_c = w;
    @(posedge clk); #1;
    start_c = 1'b0;
    @(negedge clk);
    check("c_chunk", {valid_c, busy_c, dout_c}, {2'b11, w});
    @(negedge clk);
    check("c_done", {done_c, valid_c, busy_c}, 3'b100);
    @(negedge clk);
    check("c_done_pulse", done_c, 1'b0);
  endtask

  localparam logic [127:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    logic [127:0] wb;
    int n;
    // Reset and idle
    #12;
    check("reset_outs", {busy_a, valid_a, done_a, dout_a}, 11'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_outs", {busy_a, valid_a, done_a, dout_a}, 11'h0);

    // Straight through, full rate
    rmode = 0;
    wait_idle();
    start_word(W0);
    finish_word(1, 0);

    // Backpressure pattern
    rmode = 1;
    wait_idle();
    start_word(W0);
    finish_word(0, 0);

    // start pulses while busy are ignored, then back-to-back on done
    rmode = 0;
    wait_idle();
    start_word({$urandom, $urandom, $urandom, $urandom});
    finish_word(1, 1);
    wb = {$urandom, $urandom, $urandom, $urandom};
    start_word(wb);   // issued in the done cycle
    finish_word(1, 0);
    check("b2b_drained", exp_q.size(), 0);

    // Reset mid-word after 5 transfers
    wait_idle();
    n = ntx;
    start_word(W0);
    begin
      int t = 0;
      while (ntx - n < 5 && t < 100) begin @(posedge clk); t++; end
      if (t >= 100) check("xfer_timeout", 1, 0);
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset", {busy_a, valid_a, done_a, dout_a}, 11'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("no_done_after_reset", dones, exp_dones);
    rst_n = 1'b1;
    n = ntx;
    wait_idle();
    start_word(W0);
    finish_word(1, 0);
    check("full_after_reset", ntx - n, 16);

    // Random words, random backpressure
    rmode = 2;
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      start_word({$urandom, $urandom, $urandom, $urandom});
      finish_word(0, 0);
    end
    rmode = 0;
    check("sb_empty", exp_q.size(), 0);

    // Padding and degenerate widths
    run_b(12'hABC);
    run_b(12'(($urandom)));
    run_c(8'h5A);
    run_c(8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    check("global_timeout", 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
